// File: rtl/fft_out_reorder.sv
// Reorders one bit-reversed FFT frame into natural order through a two-bank ping-pong buffer.
// Latency: first output (k=0) two edges after a frame's last sample; no backpressure, and input may have gaps.
module fft_out_reorder #(
    parameter int N     = 32,
    parameter int LOG2N = 5,
    parameter int DW    = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [DW-1:0]    data_in_r,
    input  logic signed [DW-1:0]    data_in_i,
    output logic                    valid_o,
    output logic signed [DW-1:0]    data_out_r,
    output logic signed [DW-1:0]    data_out_i,
    output logic [LOG2N-1:0]        index_o
);

    localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);

    typedef enum logic {IDLE, READ} state_t;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = a[LOG2N-1-b];
        return r;
    endfunction

    logic [2*DW-1:0]   mem [2*N];

    state_t            state_q, state_d;
    logic [LOG2N-1:0]  wcnt_q, wcnt_d;
    logic [LOG2N-1:0]  rcnt_q, rcnt_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [1:0]        full_q, full_d;
    logic              valid_q;
    logic [DW-1:0]     dout_r_q, dout_i_q;
    logic [LOG2N-1:0]  index_q;

    logic              rd_en, rd_last;
    logic              wr_ok, wr_en, wr_last;
    logic [2*DW-1:0]   rd_word;

    always_comb begin
        rd_en   = (state_q == READ);
        rd_last = rd_en && (rcnt_q == LAST);
    end

    // The bank being released this edge may take the next frame's first write (address 0 vs N-1).
    always_comb begin
        wr_ok   = !full_q[wb_q] || (rd_last && (rb_q == wb_q));
        wr_en   = valid_i && wr_ok;
        wr_last = wr_en && (wcnt_q == LAST);
        rd_word = mem[{rb_q, rcnt_q}];
    end

    always_comb begin
        full_d = full_q;
        if (rd_last) full_d[rb_q] = 1'b0;
        if (wr_last) full_d[wb_q] = 1'b1;
        wcnt_d = wcnt_q;
        wb_d   = wb_q;
        if (wr_en) begin
            wcnt_d = wr_last ? '0 : wcnt_q + 1'b1;
            wb_d   = wr_last ? ~wb_q : wb_q;
        end
        rcnt_d = '0;
        rb_d   = rb_q;
        if (rd_en) begin
            rcnt_d = rd_last ? '0 : rcnt_q + 1'b1;
            rb_d   = rd_last ? ~rb_q : rb_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[rb_q]) state_d = READ;
            READ:    if (rd_last) state_d = full_d[~rb_q] ? READ : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt_q <= '0;
            rcnt_q <= '0;
            wb_q   <= 1'b0;
            rb_q   <= 1'b0;
            full_q <= 2'b00;
        end else begin
            wcnt_q <= wcnt_d;
            rcnt_q <= rcnt_d;
            wb_q   <= wb_d;
            rb_q   <= rb_d;
            full_q <= full_d;
        end
    end

    // Buffer contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) mem[{wb_q, bitrev(wcnt_q)}] <= {data_in_r, data_in_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            dout_r_q <= '0;
            dout_i_q <= '0;
            index_q  <= '0;
        end else begin
            valid_q <= rd_en;
            if (rd_en) begin
                dout_r_q <= rd_word[2*DW-1:DW];
                dout_i_q <= rd_word[DW-1:0];
                index_q  <= rcnt_q;
            end
        end
    end

    always_comb begin
        valid_o    = valid_q;
        data_out_r = dout_r_q;
        data_out_i = dout_i_q;
        index_o    = index_q;
    end

endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed bench for fft_out_reorder against a frame-level reorder model with an output schedule.
module tb_fft_out_reorder;

    localparam int N  = 32;
    localparam int L  = 5;
    localparam int DW = 17;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   valid_i;
    logic signed [DW-1:0]   data_in_r, data_in_i;
    logic                   valid_o;
    logic signed [DW-1:0]   data_out_r, data_out_i;
    logic [L-1:0]           index_o;

    fft_out_reorder #(.N(N), .LOG2N(L), .DW(DW)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i),
        .data_in_r(data_in_r), .data_in_i(data_in_i),
        .valid_o(valid_o), .data_out_r(data_out_r), .data_out_i(data_out_i),
        .index_o(index_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int            cyc;
        logic [DW-1:0] r;
        logic [DW-1:0] i;
        int            k;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] fb_r[N];
    logic [DW-1:0] fb_i[N];
    int            wpos      = 0;
    int            next_free = 0;
    int            last_acc  = 0;
    int            last_start = 0;
    int            compared  = 0;
    int            mismatched = 0;
    bit            chk_en    = 0;
    bit            t1_rel    = 0;
    int            rst_chk_cyc = -1;
    int            run = 0;
    int            last_run = 0;
    int            first_vld = 0;
    bit            prev_vld = 0;

    function automatic int brev(input int a);
        int r = 0;
        for (int b = 0; b < L; b++) if (a[b]) r |= (1 << (L - 1 - b));
        return r;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Drives one sample for the next edge and updates the frame model; the reader
    // starts a frame two edges after its last sample, or right after the previous frame.
    task automatic send(input logic [DW-1:0] r, input logic [DW-1:0] i);
        @(posedge clk); #1;
        valid_i   = 1'b1;
        data_in_r = r;
        data_in_i = i;
        fb_r[brev(wpos)] = r;
        fb_i[brev(wpos)] = i;
        wpos++;
        if (wpos == N) begin
            int start;
            exp_t e;
            last_acc = cyc + 1;
            start = (last_acc + 2 > next_free) ? last_acc + 2 : next_free;
            for (int k = 0; k < N; k++) begin
                e.cyc = start + k; e.r = fb_r[k]; e.i = fb_i[k]; e.k = k;
                q.push_back(e);
            end
            last_start = start;
            next_free  = start + N;
            wpos = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) begin
            @(posedge clk); #1;
            valid_i = 1'b0;
        end
    endtask

    // Called just after an edge: reset takes effect at the following edge.
    task automatic do_reset();
        int c;
        rst = 1'b1;
        valid_i = 1'b0;
        c = cyc;
        while (q.size() > 0 && q[q.size()-1].cyc > c) void'(q.pop_back());
        wpos = 0;
        next_free = 0;
        rst_chk_cyc = c + 1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && q.size() > 0; n++) @(posedge clk);
        if (q.size() > 0) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout: %0d outputs still pending, expected 0", q.size());
        end
        idle(4);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
                compared++; mismatched++;
                $display("FAIL sched_missed: k=%0d due cycle %0d unobserved", q[0].k, q[0].cyc);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("valid_o", {31'b0, valid_o}, 32'd1);
                check("data_out_r", {15'b0, data_out_r}, {15'b0, q[0].r});
                check("data_out_i", {15'b0, data_out_i}, {15'b0, q[0].i});
                check("index_o", {27'b0, index_o}, q[0].k);
                void'(q.pop_front());
            end else begin
                check("valid_o_idle", {31'b0, valid_o}, 32'd0);
            end
            if (t1_rel && valid_o) begin
                logic [DW-1:0] ni;
                ni = DW'(0) - DW'(index_o);
                check("t1_r_eq_k", {15'b0, data_out_r}, {27'b0, index_o});
                check("t1_i_eq_negk", {15'b0, data_out_i}, {15'b0, ni});
            end
            if (cyc == rst_chk_cyc) begin
                check("rst_valid", {31'b0, valid_o}, 32'd0);
                check("rst_dr", {15'b0, data_out_r}, 32'd0);
                check("rst_di", {15'b0, data_out_i}, 32'd0);
                check("rst_idx", {27'b0, index_o}, 32'd0);
            end
        end
        if (valid_o === 1'b1) begin
            if (!prev_vld) first_vld = cyc;
            run++;
        end else begin
            if (prev_vld) last_run = run;
            run = 0;
        end
        prev_vld = (valid_o === 1'b1);
    end

    initial begin
        rst = 1'b1; valid_i = 1'b0; data_in_r = '0; data_in_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", {31'b0, valid_o}, 32'd0);
        check("reset_dr", {15'b0, data_out_r}, 32'd0);
        check("reset_di", {15'b0, data_out_i}, 32'd0);
        check("reset_idx", {27'b0, index_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // 1: single frame, sample value equals its natural index
        t1_rel = 1'b1;
        for (int p = 0; p < N; p++) send(DW'(brev(p)), DW'(-brev(p)));
        idle(1);
        drain();
        t1_rel = 1'b0;
        check("t1_run", last_run, 32'd32);
        check("t1_latency", first_vld - last_acc, 32'd2);

        // 2: three frames back to back with frame tag in the upper bits
        for (int f = 0; f < 3; f++)
            for (int p = 0; p < N; p++)
                send(DW'(brev(p) + (f << 8)), DW'(-(brev(p) + (f << 8))));
        idle(1);
        drain();
        check("t2_run", last_run, 32'd96);

        // 3: gapped input, one sample every third cycle
        t1_rel = 1'b1;
        for (int p = 0; p < N; p++) begin
            send(DW'(brev(p)), DW'(-brev(p)));
            idle(2);
        end
        drain();
        t1_rel = 1'b0;
        check("t3_run", last_run, 32'd32);
        check("t3_latency", first_vld - last_acc, 32'd2);

        // 4: reset after 10 samples, then a clean frame
        for (int p = 0; p < 10; p++) send(DW'(100 + p), DW'(200 + p));
        @(posedge clk); #1;
        do_reset();
        idle(40);
        check("t4_no_output", {31'b0, valid_o}, 32'd0);
        for (int p = 0; p < N; p++) send(DW'(brev(p)), DW'(-brev(p)));
        idle(1);
        drain();
        check("t4_run", last_run, 32'd32);

        // 5: reset while index 12 of a frame is on the output
        for (int p = 0; p < N; p++) send(DW'(brev(p) + 17'h300), DW'(brev(p)));
        idle(1);
        for (int n = 0; n < 100 && cyc != last_start + 12; n++) begin
            @(posedge clk); #1;
        end
        do_reset();
        idle(60);
        check("t5_run", last_run, 32'd13);

        // 6: DW extremes
        for (int p = 0; p < N; p++)
            if (p % 2 == 1) send(17'h0FFFF, 17'h10000);
            else            send(17'h10000, 17'h0FFFF);
        idle(1);
        drain();
        check("t6_run", last_run, 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
